// File: rtl/ahfp_mult_sched.sv
// Two-requester scheduler that time-shares one combinational IEEE-754 single multiplier.
// ahfp_mult is the shared multiplier: normal operands, round-to-nearest-even, no special-value handling.
module ahfp_mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic              sign;
    logic              zero_in;
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;
    logic signed [9:0] exp_norm;
    logic signed [9:0] exp_fin;
    logic [24:0]       rounded;
    logic [22:0]       frac;

    function automatic logic [24:0] round_rne(input logic [23:0] man, input logic guard,
                                              input logic sticky);
        return {1'b0, man} + 25'(guard & (sticky | man[0]));
    endfunction

    // Out-of-range exponents saturate to infinity or flush to zero.
    function automatic logic [31:0] sat_pack(input logic s, input logic signed [9:0] e,
                                             input logic [22:0] f, input logic z);
        if (z || e <= 10'sd0)
            return {s, 31'b0};
        else if (e >= 10'sd255)
            return {s, 8'hFF, 23'b0};
        else
            return {s, e[7:0], f};
    endfunction

    always_comb begin
        sign     = a[31] ^ b[31];
        zero_in  = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
        prod     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        exp_sum  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        exp_norm = exp_sum;
        if (prod[47]) begin
            rounded  = round_rne(prod[47:24], prod[23], |prod[22:0]);
            exp_norm = exp_sum + 10'sd1;
        end else begin
            rounded  = round_rne(prod[46:23], prod[22], |prod[21:0]);
        end
        exp_fin = rounded[24] ? exp_norm + 10'sd1 : exp_norm;
        frac    = rounded[24] ? 23'd0 : rounded[22:0];
        p       = sat_pack(sign, exp_fin, frac, zero_in);
    end
endmodule

module ahfp_mult_sched #(
    parameter int MULT_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    output logic        done0,
    output logic [31:0] res0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done1,
    output logic [31:0] res1,
    output logic        busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic        prio;
    logic        grant;
    logic [3:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] product;

    ahfp_mult u_mult (
        .a(opa),
        .b(opb),
        .p(product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            grant    <= 1'b0;
            cnt      <= 4'd0;
            opa      <= 32'd0;
            opb      <= 32'd0;
            res0     <= 32'd0;
            res1     <= 32'd0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            op_count <= 16'd0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        // Port 0 wins when alone or when it holds the priority token.
                        if (req0 && (!req1 || !prio)) begin
                            grant <= 1'b0;
                            opa   <= a0;
                            opb   <= b0;
                            prio  <= 1'b1;
                        end else begin
                            grant <= 1'b1;
                            opa   <= a1;
                            opb   <= b1;
                            prio  <= 1'b0;
                        end
                        cnt   <= 4'(MULT_LAT);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (grant) begin
                            res1  <= product;
                            done1 <= 1'b1;
                        end else begin
                            res0  <= product;
                            done0 <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    op_count <= op_count + 16'd1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahfp_mult_sched.sv
// Bench for ahfp_mult_sched: directed scenarios plus randomized traffic against a float-multiply model.
module tb_ahfp_mult_sched;
    localparam int LAT  = 1;
    localparam int LAT4 = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
    logic        done0, done1, busy;
    logic [31:0] res0, res1;
    logic [15:0] op_count;

    logic        req4 = 1'b0, zero_req = 1'b0;
    logic [31:0] a4 = 32'd0, b4 = 32'd0, zero_op = 32'd0;
    logic        d4_0, d4_1, busy4;
    logic [31:0] r4_0, r4_1;
    logic [15:0] cnt4;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          mprio;
    logic [31:0] mres0, mres1;
    logic [15:0] mcount;
    int          last_done;

    ahfp_mult_sched #(.MULT_LAT(LAT)) u1 (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .a0(a0), .b0(b0), .done0(done0), .res0(res0),
        .req1(req1), .a1(a1), .b1(b1), .done1(done1), .res1(res1),
        .busy(busy), .op_count(op_count)
    );

    ahfp_mult_sched #(.MULT_LAT(LAT4)) u4 (
        .clk(clk), .reset_n(reset_n),
        .req0(req4), .a0(a4), .b0(b4), .done0(d4_0), .res0(r4_0),
        .req1(zero_req), .a1(zero_op), .b1(zero_op), .done1(d4_1), .res1(r4_1),
        .busy(busy4), .op_count(cnt4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Exact significand product, then round-half-even by remainder comparison.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic            s;
        int              e, sh;
        longint unsigned p, q, rem, half;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) return {s, 31'b0};
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
    endfunction

    task automatic model_reset;
        mprio  = 1'b0;
        mres0  = 32'd0;
        mres1  = 32'd0;
        mcount = 16'd0;
    endtask

    // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
    task automatic serve(input bit hold, input bit corrupt, output bit w);
        logic [31:0] exp_res;
        int          lat;
        bit          got;
        if (req0 && req1) w = mprio;
        else w = req1;
        exp_res = w ? ref_mul(a1, b1) : ref_mul(a0, b0);
        mprio   = !w;
        lat     = 0;
        got     = 1'b0;
        while (!got && lat < 40) begin
            tick;
            lat++;
            if (lat == 1) begin
                check("busy_calc", 32'(busy), 32'd1);
                if (corrupt) begin
                    if (w) begin
                        a1 = 32'hFFFFFFFF;
                        b1 = rnd_op();
                    end else begin
                        a0 = 32'hFFFFFFFF;
                        b0 = rnd_op();
                    end
                end
            end
            if (done0 || done1) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(LAT + 1));
        check("done0", 32'(done0), 32'(!w));
        check("done1", 32'(done1), 32'(w));
        check(w ? "res1" : "res0", w ? res1 : res0, exp_res);
        check(w ? "res0_kept" : "res1_kept", w ? res0 : res1, w ? mres0 : mres1);
        if (w) mres1 = exp_res;
        else mres0 = exp_res;
        mcount++;
        last_done = cyc;
        if (!hold) begin
            if (w) req1 = 1'b0;
            else req0 = 1'b0;
        end
        tick;
        check("done_width", 32'(done0 | done1), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("op_count", 32'(op_count), 32'(mcount));
    endtask

    initial begin
        bit w;
        int t0, lat;
        bit seen;

        model_reset();
        last_done = -100;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_res0", res0, 32'd0);
        check("rst_res1", res1, 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        reset_n = 1'b1;
        tick;

        // Single request: 1.0 * 2.0
        a0 = 32'h3F800000; b0 = 32'h40000000; req0 = 1'b1;
        serve(1'b0, 1'b0, w);
        check("single_res0", res0, 32'h40000000);
        check("single_count", 32'(op_count), 32'd1);

        // Simultaneous requests straight after reset
        reset_n = 1'b0;
        tick;
        model_reset();
        reset_n = 1'b1;
        tick;
        a0 = 32'h40400000; b0 = 32'h40600000;
        a1 = 32'h43FA0000; b1 = 32'h41133333;
        req0 = 1'b1; req1 = 1'b1;
        serve(1'b0, 1'b0, w);
        check("sim_first", 32'(w), 32'd0);
        check("sim_res0", res0, 32'h41280000);
        t0 = last_done;
        serve(1'b0, 1'b0, w);
        check("sim_second", 32'(w), 32'd1);
        check("sim_res1", res1, 32'h458FC000);
        check("sim_spacing", 32'(last_done - t0), 32'd3);

        // Fairness with both requests held continuously
        a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(1'b1, 1'b0, w);
            check("fair_grant", 32'(w), 32'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick;

        // Operand corruption after grant: 5.0 * 3.0
        a0 = 32'h40A00000; b0 = 32'h40400000; req0 = 1'b1;
        serve(1'b0, 1'b1, w);
        check("corrupt_res0", res0, 32'h41700000);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!req0 && ($urandom % 4 != 0)) begin
                req0 = 1'b1; a0 = rnd_op(); b0 = rnd_op();
            end
            if (!req1 && ($urandom % 4 != 0)) begin
                req1 = 1'b1; a1 = rnd_op(); b1 = rnd_op();
            end
            if (!req0 && !req1) begin
                req0 = 1'b1; a0 = rnd_op(); b0 = rnd_op();
            end
            serve(1'b0, ($urandom % 3) == 0, w);
        end
        for (int n = 0; n < 2; n++)
            if (req0 || req1) serve(1'b0, 1'b0, w);

        // op_count wrap via preload
        force u1.op_count = 16'hFFFF;
        #1;
        release u1.op_count;
        mcount = 16'hFFFF;
        check("wrap_preload", 32'(op_count), 32'h0000FFFF);
        req0 = 1'b1; a0 = rnd_op(); b0 = rnd_op();
        serve(1'b0, 1'b0, w);
        check("wrap_zero", 32'(op_count), 32'd0);
        req1 = 1'b1; a1 = rnd_op(); b1 = rnd_op();
        serve(1'b0, 1'b0, w);
        check("wrap_continue", 32'(op_count), 32'd1);

        // Reset in the middle of CALC on the MULT_LAT=4 instance
        req4 = 1'b1; a4 = 32'h3F800000; b4 = 32'h40400000;
        tick;
        tick;
        check("abort_busy_before", 32'(busy4), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_res0", r4_0, 32'd0);
        check("abort_done0", 32'(d4_0), 32'd0);
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_count", 32'(cnt4), 32'd0);
        check("abort_u1_res1", res1, 32'd0);
        req4 = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick;
            if (d4_0) seen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (6) begin
            tick;
            if (d4_0) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_count_after", 32'(cnt4), 32'd0);
        req4 = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            tick;
            lat++;
            if (d4_0) seen = 1'b1;
        end
        check("reissue_done", 32'(seen), 32'd1);
        check("reissue_latency", 32'(lat), 32'(LAT4 + 1));
        check("reissue_res0", r4_0, 32'h40400000);
        req4 = 1'b0;
        tick;
        check("reissue_count", 32'(cnt4), 32'd1);
        check("reissue_busy", 32'(busy4), 32'd0);
        check("reissue_res1", r4_1, 32'd0);
        check("reissue_done1", 32'(d4_1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahfp_mult_sched.md
AHFP_MULT_SCHED -- requirements
Module: ahfp_mult_sched

Interface
REQ-001 The block SHALL have parameter MULT_LAT, default 1, giving the cycles (1..15) allowed for the combinational product to settle after operand capture.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port req0, input, 1, requester 0 asks for a multiply; it is held high until done0.
REQ-005 Ports a0 and b0, input, 32 each, requester 0 IEEE-754 single operands; they are held stable while req0 is high.
REQ-006 Port done0, output, 1, one-cycle pulse; res0 is valid in that cycle.
REQ-007 Port res0, output, 32, requester 0 product, registered.
REQ-008 Ports req1, a1, b1, done1 and res1 SHALL be identical to the requester-0 ports, for requester 1.
REQ-009 Port busy, output, 1, high whenever the FSM is not IDLE.
REQ-010 Port op_count, output, 16, number of completed multiplies; it wraps modulo 2^16.

Function
REQ-011 The block SHALL instantiate exactly one ahfp_mult and share it between the two requesters; the block SHALL NOT instantiate any other multiplier.
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE: if any req is high, the FSM SHALL grant one port, capture its a/b into operand registers opa/opb, load cnt=MULT_LAT and move to CALC; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin with a 1-bit priority pointer prio; if only one req is high, that port SHALL win; if both are high, port prio SHALL win.
REQ-015 After a grant to port p, prio SHALL become !p.
REQ-016 CALC: cnt SHALL decrement each cycle; when cnt==1, the FSM SHALL write the ahfp_mult result(opa,opb) into res of the granted port and move to DONE.
REQ-017 DONE: done of the granted port SHALL be high for exactly this one cycle; op_count SHALL increment; the FSM SHALL move to IDLE.
REQ-018 Latency SHALL be MULT_LAT+1 cycles from a req seen in IDLE (cycle 0) to done (cycle MULT_LAT+1); one operation SHALL take MULT_LAT+2 cycles including the IDLE cycle.
REQ-019 A requester SHALL deassert req on the edge that ends its done cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-020 req and operand changes during CALC or DONE SHALL NOT affect opa, opb or the result in flight; operands SHALL be sampled only at the grant edge.
REQ-021 res0 and res1 SHALL hold their last value until that port's next result is written; writing one port's result SHALL leave the other port's res unchanged.
REQ-022 done0 and done1 SHALL never be high in the same cycle.
REQ-023 Each requester SHALL receive a grant within two operations of raising req (starvation-free).
REQ-024 op_count SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-025 The block SHALL perform no float checks; special values SHALL pass straight through ahfp_mult.

Reset
REQ-026 While reset_n is low, the block SHALL hold: FSM=IDLE, prio=0, cnt=0, opa=opb=0, res0=res1=0, done0=done1=0, busy=0, op_count=0.
REQ-027 A reset during CALC or DONE SHALL abort the operation; the block SHALL raise no done and SHALL NOT increment op_count; the requester SHALL re-request.
REQ-028 Leaving reset SHALL be synchronous to clk; the first grant SHALL occur no earlier than the first rising edge with reset_n high.

Verification
REQ-029 Single request, MULT_LAT=1: req0 with a0=3F800000, b0=40000000 -> done0 in cycle 2, res0=40000000, op_count=1.
REQ-030 Simultaneous requests after reset: req0 with 40400000*40600000, req1 with 43FA0000*41133333 -> port 0 served first, res0=41280000; then port 1, res1=458FC000; done pulses 3 cycles apart.
REQ-031 Fairness: both reqs held continuously for 6 operations -> grants alternate 0,1,0,1,0,1 and each done is exactly one cycle wide.
REQ-032 Operand corruption: change a0 to FFFFFFFF during CALC -> res0 equals the product of the operands captured at grant.
REQ-033 Reset mid-CALC, MULT_LAT=4: pull reset_n low in cycle 2 -> all outputs zero, no done pulse; after release, a re-issued request completes normally.
REQ-034 Wrap: force 65536 operations (or preload) -> op_count returns to 0000 and the FSM continues normally.
